// File: rtl/apb_uart_rxbuf_if.sv
// APB slave bus plus UART receive character stream for apb_uart_rxbuf.
// master drives APB requests and received characters; slave is the buffer.
interface apb_uart_rxbuf_if #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 8
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    logic [DATA_WIDTH-1:0]     rx_data_i;
    logic                      rx_perr_i;
    logic                      rx_valid_i;
    logic                      rx_ready_o;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR,
        output rx_data_i, rx_perr_i, rx_valid_i,
        input  rx_ready_o
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR,
        input  rx_data_i, rx_perr_i, rx_valid_i,
        output rx_ready_o
    );
endinterface

// File: rtl/apb_uart_rxbuf.sv
// UART receive FIFO with APB register access, sticky error flags and level interrupt.
// Optional receive timeout logic is enabled by defining APB_UART_RXBUF_TIMEOUT_EN.
module apb_uart_rxbuf #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic            CLK,
    input  logic            RSTN,
    apb_uart_rxbuf_if.slave bus,
    output logic            event_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic                  access, rd, wr;
    logic [2:0]            sel;
    logic                  data_rd, status_rd, ctrl_wr, timeout_wr, flush;
    logic                  empty, full, pop, push_req, push;
    logic                  oe_set, pe_set, uf_set;

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   head;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, trig;

    logic                  oe_q, pe_q, uf_q;
    logic [1:0]            trig_q;
    logic                  ie_rda_q, ie_to_q, ie_err_q;
    logic [TIMEOUT_WIDTH-1:0] timeout_q;
    logic                  to_q;
    logic [31:0]           prdata;
    logic                  unused_bits;

    assign access     = bus.PSEL & bus.PENABLE;
    assign sel        = bus.PADDR[4:2];
    assign rd         = access & ~bus.PWRITE;
    assign wr         = access & bus.PWRITE;
    assign data_rd    = rd & (sel == 3'd0);
    assign status_rd  = rd & (sel == 3'd1);
    assign ctrl_wr    = wr & (sel == 3'd2);
    assign timeout_wr = wr & (sel == 3'd3);
    assign flush      = ctrl_wr & bus.PWDATA[2];

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = data_rd & ~empty;
    assign uf_set   = data_rd & empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_req = bus.rx_valid_i & ~flush;
    assign push     = push_req & (~full | pop);
    assign oe_set   = push_req & full & ~pop;
    assign pe_set   = push & bus.rx_perr_i;
    assign head     = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {bus.rx_perr_i, bus.rx_data_i};
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            oe_q     <= 1'b0;
            pe_q     <= 1'b0;
            uf_q     <= 1'b0;
            trig_q   <= 2'd0;
            ie_rda_q <= 1'b0;
            ie_to_q  <= 1'b0;
            ie_err_q <= 1'b0;
        end else begin
            oe_q <= oe_set | (oe_q & ~status_rd);
            pe_q <= pe_set | (pe_q & ~status_rd);
            uf_q <= uf_set | (uf_q & ~status_rd);
            if (ctrl_wr) begin
                trig_q   <= bus.PWDATA[1:0];
                ie_rda_q <= bus.PWDATA[4];
                ie_to_q  <= bus.PWDATA[5];
                ie_err_q <= bus.PWDATA[6];
            end
        end
    end

`ifdef APB_UART_RXBUF_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] to_cnt, to_cnt_nxt;

    assign to_cnt_nxt = to_cnt + 1'b1;

    // Counter stops once TO is raised; any FIFO activity restarts the idle window.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            timeout_q <= '0;
            to_cnt    <= '0;
            to_q      <= 1'b0;
        end else begin
            if (timeout_wr) timeout_q <= bus.PWDATA[TIMEOUT_WIDTH-1:0];
            if (flush || push || pop) begin
                to_cnt <= '0;
                to_q   <= 1'b0;
            end else if (!empty && (timeout_q != '0) && !to_q) begin
                to_cnt <= to_cnt_nxt;
                if (to_cnt_nxt == timeout_q) to_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_q = '0;
    assign to_q      = 1'b0;
`endif

    always_comb begin
        case (trig_q)
            2'd0:    trig = CW'(1);
            2'd1:    trig = CW'(FIFO_DEPTH / 4);
            2'd2:    trig = CW'(FIFO_DEPTH / 2);
            default: trig = CW'(FIFO_DEPTH - 2);
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) event_o <= 1'b0;
        else       event_o <= (ie_rda_q & (count >= trig)) | (ie_to_q & to_q) |
                              (ie_err_q & (oe_q | pe_q));
    end

    always_comb begin
        prdata = '0;
        if (rd) begin
            case (sel)
                3'd0: begin
                    if (!empty) begin
                        prdata[DATA_WIDTH-1:0] = head[DATA_WIDTH-1:0];
                        prdata[16]             = head[DATA_WIDTH];
                    end
                end
                3'd1:    prdata[5:0] = {uf_q, to_q, pe_q, oe_q, full, ~empty};
                3'd2:    prdata[6:0] = {ie_err_q, ie_to_q, ie_rda_q, 2'b00, trig_q};
                3'd3:    prdata = 32'(timeout_q);
                3'd4:    prdata = 32'(count);
                default: prdata = '0;
            endcase
        end
    end

    assign bus.PRDATA     = prdata;
    assign bus.PREADY     = 1'b1;
    assign bus.PSLVERR    = access & ((sel > 3'd4) |
                            (bus.PWRITE & ((sel == 3'd0) | (sel == 3'd1) | (sel == 3'd4))));
    assign bus.rx_ready_o = 1'b1;

    assign unused_bits = ^{bus.PWDATA, bus.PADDR, timeout_wr};
endmodule

// File: tb/tb_apb_uart_rxbuf.sv
// Directed bench for apb_uart_rxbuf: FIFO order, flags, interrupts, flush and reset.
module tb_apb_uart_rxbuf;
    logic CLK;
    logic RSTN;
    logic event_o;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rdata;
    logic        err;

    apb_uart_rxbuf_if #(.APB_ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();

    apb_uart_rxbuf #(
        .APB_ADDR_WIDTH(12),
        .DATA_WIDTH(8),
        .FIFO_DEPTH(16),
        .TIMEOUT_WIDTH(16)
    ) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .bus(bus),
        .event_o(event_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_access(input logic w, input logic [2:0] sel, input logic [31:0] wdata,
                              input logic rxv, input logic [7:0] rxd,
                              output logic [31:0] rd_val, output logic rd_err);
        bus.PADDR   = {7'b0, sel, 2'b00};
        bus.PWRITE  = w;
        bus.PWDATA  = wdata;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        tick();
        bus.PENABLE    = 1'b1;
        bus.rx_valid_i = rxv;
        bus.rx_data_i  = rxd;
        bus.rx_perr_i  = 1'b0;
        #1;
        rd_val = bus.PRDATA;
        rd_err = bus.PSLVERR;
        tick();
        bus.PSEL       = 1'b0;
        bus.PENABLE    = 1'b0;
        bus.PWRITE     = 1'b0;
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic apb_rd(input logic [2:0] sel, output logic [31:0] rd_val);
        logic e;
        apb_access(1'b0, sel, 32'h0, 1'b0, 8'h00, rd_val, e);
    endtask

    task automatic apb_wr(input logic [2:0] sel, input logic [31:0] wdata);
        logic [31:0] d;
        logic        e;
        apb_access(1'b1, sel, wdata, 1'b0, 8'h00, d, e);
    endtask

    task automatic push(input logic [7:0] d, input logic perr);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = d;
        bus.rx_perr_i  = perr;
        tick();
        bus.rx_valid_i = 1'b0;
        bus.rx_perr_i  = 1'b0;
    endtask

    initial begin
        bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        bus.rx_data_i = '0; bus.rx_perr_i = 1'b0; bus.rx_valid_i = 1'b0;
        RSTN = 1'b0;
        #3;
        chk("reset_event", 32'(event_o), 32'h0);
        tick(); tick();
        RSTN = 1'b1;
        tick();

        chk("pready", 32'(bus.PREADY), 32'h1);
        chk("rx_ready", 32'(bus.rx_ready_o), 32'h1);
        apb_rd(3'd1, rdata); chk("reset_status", rdata, 32'h0);
        apb_rd(3'd4, rdata); chk("reset_level", rdata, 32'h0);
        apb_rd(3'd2, rdata); chk("reset_ctrl", rdata, 32'h0);

        // basic ordering and underflow
        push(8'h41, 1'b0);
        push(8'h42, 1'b0);
        apb_rd(3'd4, rdata); chk("level_2", rdata, 32'h2);
        apb_rd(3'd1, rdata); chk("status_ne", rdata, 32'h01);
        apb_rd(3'd0, rdata); chk("data_41", rdata, 32'h41);
        apb_rd(3'd0, rdata); chk("data_42", rdata, 32'h42);
        apb_rd(3'd0, rdata); chk("data_empty", rdata, 32'h0);
        apb_rd(3'd1, rdata); chk("status_uf", rdata, 32'h20);
        apb_rd(3'd1, rdata); chk("status_uf_clr", rdata, 32'h00);

        // slave error decode
        apb_access(1'b1, 3'd0, 32'h99, 1'b0, 8'h00, rdata, err);
        chk("slverr_wr_data", 32'(err), 32'h1);
        apb_access(1'b0, 3'd5, 32'h0, 1'b0, 8'h00, rdata, err);
        chk("slverr_sel5", 32'(err), 32'h1);
        apb_access(1'b0, 3'd1, 32'h0, 1'b0, 8'h00, rdata, err);
        chk("slverr_status", 32'(err), 32'h0);
        apb_rd(3'd4, rdata); chk("level_after_bad_wr", rdata, 32'h0);

        // overflow and push-at-full with simultaneous pop
        for (int i = 0; i < 17; i++) push(8'(8'h60 + i), 1'b0);
        apb_rd(3'd4, rdata); chk("level_full", rdata, 32'd16);
        apb_rd(3'd1, rdata); chk("status_oe", rdata, 32'h07);
        apb_access(1'b0, 3'd0, 32'h0, 1'b1, 8'hAA, rdata, err);
        chk("pop_at_full_data", rdata, 32'h60);
        apb_rd(3'd4, rdata); chk("level_push_pop", rdata, 32'd16);
        apb_rd(3'd1, rdata); chk("status_no_oe", rdata, 32'h03);
        apb_wr(3'd2, 32'h04);
        apb_rd(3'd4, rdata); chk("level_flushed", rdata, 32'h0);

        // RDA trigger at half depth
        apb_wr(3'd2, 32'h12);
        apb_rd(3'd2, rdata); chk("ctrl_rb", rdata, 32'h12);
        for (int i = 0; i < 7; i++) push(8'(i), 1'b0);
        tick();
        chk("rda_7", 32'(event_o), 32'h0);
        push(8'h07, 1'b0);
        chk("rda_8_same", 32'(event_o), 32'h0);
        tick();
        chk("rda_8_next", 32'(event_o), 32'h1);
        apb_rd(3'd0, rdata);
        tick();
        chk("rda_after_pop", 32'(event_o), 32'h0);
        apb_wr(3'd2, 32'h04);

        // receive timeout
`ifdef APB_UART_RXBUF_TIMEOUT_EN
        apb_wr(3'd3, 32'd10);
        apb_rd(3'd3, rdata); chk("timeout_rb", rdata, 32'd10);
        apb_wr(3'd2, 32'h20);
        push(8'h11, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("to_event_early", 32'(event_o), 32'h0);
        tick();
        chk("to_event", 32'(event_o), 32'h1);
        apb_rd(3'd1, rdata); chk("status_to", rdata, 32'h11);
        apb_rd(3'd0, rdata); chk("to_data", rdata, 32'h11);
        apb_rd(3'd1, rdata); chk("status_to_clr", rdata, 32'h00);
        apb_wr(3'd3, 32'd0);
`else
        apb_access(1'b1, 3'd3, 32'd10, 1'b0, 8'h00, rdata, err);
        chk("timeout_wr_noerr", 32'(err), 32'h0);
        apb_rd(3'd3, rdata); chk("timeout_rb_zero", rdata, 32'h0);
        apb_wr(3'd2, 32'h20);
        push(8'h11, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("to_never", 32'(event_o), 32'h0);
        apb_rd(3'd1, rdata); chk("status_no_to", rdata, 32'h01);
        apb_rd(3'd0, rdata); chk("to_data", rdata, 32'h11);
`endif
        apb_wr(3'd2, 32'h00);

        // parity error interrupt
        apb_wr(3'd2, 32'h40);
        push(8'h55, 1'b1);
        tick();
        chk("pe_event", 32'(event_o), 32'h1);
        apb_rd(3'd0, rdata); chk("pe_data", rdata, 32'h0001_0055);
        apb_rd(3'd1, rdata); chk("status_pe", rdata, 32'h08);
        tick();
        chk("pe_event_clr", 32'(event_o), 32'h0);
        apb_wr(3'd2, 32'h00);

        // flush with simultaneous push
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b0);
        apb_rd(3'd4, rdata); chk("level_5", rdata, 32'd5);
        apb_access(1'b1, 3'd2, 32'h04, 1'b1, 8'hEE, rdata, err);
        apb_rd(3'd4, rdata); chk("flush_level", rdata, 32'h0);
        apb_rd(3'd1, rdata); chk("flush_status", rdata, 32'h00);

        // reset in the middle of traffic
        for (int i = 0; i < 3; i++) push(8'(8'h20 + i), 1'b0);
        apb_wr(3'd2, 32'h50);
        apb_wr(3'd3, 32'd7);
        tick();
        chk("pre_reset_event", 32'(event_o), 32'h1);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'h77;
        #2;
        RSTN = 1'b0;
        #1;
        chk("mid_reset_event", 32'(event_o), 32'h0);
        bus.rx_valid_i = 1'b0;
        tick();
        RSTN = 1'b1;
        tick();
        apb_rd(3'd1, rdata); chk("post_reset_status", rdata, 32'h0);
        apb_rd(3'd4, rdata); chk("post_reset_level", rdata, 32'h0);
        apb_rd(3'd2, rdata); chk("post_reset_ctrl", rdata, 32'h0);
        apb_rd(3'd3, rdata); chk("post_reset_timeout", rdata, 32'h0);
        push(8'h33, 1'b0);
        apb_rd(3'd0, rdata); chk("post_reset_data", rdata, 32'h33);
        apb_rd(3'd4, rdata); chk("post_reset_level_end", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
